// File: rtl/pipe_skid_reg_pkg.sv
// Shared definitions for the elastic pipeline stage register: state
// encodings, per-stage hold-bit indices in the ctrl hold vector and the
// canonical NOP instruction used to fill empty or flushed stages.
package pipe_skid_reg_pkg;

   // State encodings double as the occupancy count (0/1/2 entries)
   localparam logic [1:0] ST_EMPTY = 2'd0;
   localparam logic [1:0] ST_FULL  = 2'd1;
   localparam logic [1:0] ST_SKID  = 2'd2;

   // Bit positions inside the ctrl hold vector, one per stage boundary
   localparam int HOLD_IF  = 0;
   localparam int HOLD_ID  = 1;
   localparam int HOLD_EX  = 2;
   localparam int HOLD_MEM = 3;
   localparam int HOLD_WB  = 4;

   // addi x0, x0, 0
   localparam logic [31:0] INST_NOP = 32'h0000_0013;

endpackage

// File: rtl/gnrl_dfflrd.sv
// General-purpose flop bank with load enable and a reset default value.
// Reset is synchronous and active-low.
module gnrl_dfflrd #(
   parameter int            DW      = 32,
   parameter logic [DW-1:0] RST_VAL = {DW{1'b0}}
) (
   input  logic          clk,
   input  logic          rstn,
   input  logic          lden,
   input  logic [DW-1:0] dnxt,
   output logic [DW-1:0] qout
);

   logic [DW-1:0] q_r;

   // Hold value unless loaded; synchronous reset to the default value
   always_ff @(posedge clk) begin
      if (!rstn) begin
         q_r <= RST_VAL;
      end else if (lden) begin
         q_r <= dnxt;
      end else begin
         q_r <= q_r;
      end
   end

   assign qout = q_r;

endmodule

// File: rtl/pipe_skid_reg.sv
// Elastic pipeline stage register with valid/ready handshake, optional
// 2-entry skid buffer (registered in_ready_o), synchronous flush that
// empties the stage and a per-stage hold bit taken from the ctrl vector.
module pipe_skid_reg
   import pipe_skid_reg_pkg::*;
#(
   parameter int            DW       = 32,
   parameter logic [DW-1:0] NOP_VAL  = {DW{1'b0}},
   parameter int            SKID     = 1,
   parameter int            CTRL_W   = 5,
   parameter int            HOLD_BIT = 3
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic [CTRL_W-1:0] hold_en_i,
   input  logic              flush_i,
   input  logic              in_valid_i,
   output logic              in_ready_o,
   input  logic [DW-1:0]     in_data_i,
   output logic              out_valid_o,
   input  logic              out_ready_i,
   output logic [DW-1:0]     out_data_o,
   output logic [1:0]        occ_o
);

   // One-hot select of this stage's bit; masking keeps the whole vector in use
   localparam logic [CTRL_W-1:0] HOLD_MASK = CTRL_W'(1'b1) << HOLD_BIT;

   logic [1:0]    state_r;
   logic [1:0]    state_nxt_s;
   logic          not_skid_r;
   logic          hold_s;
   logic          in_ready_s;
   logic          out_valid_s;
   logic          in_fire_s;
   logic          out_fire_s;
   logic          main_ld_s;
   logic [DW-1:0] main_nxt_s;
   logic [DW-1:0] main_q_s;
   logic          skid_ld_s;
   logic [DW-1:0] skid_nxt_s;
   logic [DW-1:0] skid_q_s;

   assign hold_s      = |(hold_en_i & HOLD_MASK);
   assign out_valid_s = (state_r != ST_EMPTY) & ~hold_s;
   assign in_fire_s   = in_valid_i & in_ready_s;
   assign out_fire_s  = out_valid_s & out_ready_i;

   // Input-side ready: registered skid-free flag, or pass-through of consumer ready
   always_comb begin
      in_ready_s = 1'b0;
      if (SKID != 0) begin
         in_ready_s = not_skid_r & ~hold_s;
      end else begin
         in_ready_s = ((state_r == ST_EMPTY) | out_ready_i) & ~hold_s;
      end
   end

   // Next state and entry load enables; flush beats hold beats handshake
   always_comb begin
      state_nxt_s = state_r;
      main_ld_s   = 1'b0;
      main_nxt_s  = in_data_i;
      skid_ld_s   = 1'b0;
      skid_nxt_s  = in_data_i;
      if (flush_i) begin
         state_nxt_s = ST_EMPTY;
         main_ld_s   = 1'b1;
         main_nxt_s  = NOP_VAL;
         skid_ld_s   = 1'b1;
         skid_nxt_s  = NOP_VAL;
      end else if (hold_s) begin
         state_nxt_s = state_r;
      end else begin
         case (state_r)
            ST_EMPTY: begin
               if (in_fire_s) begin
                  state_nxt_s = ST_FULL;
                  main_ld_s   = 1'b1;
               end else begin
                  state_nxt_s = ST_EMPTY;
               end
            end
            ST_FULL: begin
               if (in_fire_s && out_fire_s) begin
                  state_nxt_s = ST_FULL;
                  main_ld_s   = 1'b1;
               end else if (in_fire_s && (SKID != 0)) begin
                  state_nxt_s = ST_SKID;
                  skid_ld_s   = 1'b1;
               end else if (out_fire_s) begin
                  state_nxt_s = ST_EMPTY;
               end else begin
                  state_nxt_s = ST_FULL;
               end
            end
            ST_SKID: begin
               if (out_fire_s) begin
                  state_nxt_s = ST_FULL;
                  main_ld_s   = 1'b1;
                  main_nxt_s  = skid_q_s;
               end else begin
                  state_nxt_s = ST_SKID;
               end
            end
            default: begin
               state_nxt_s = ST_EMPTY;
            end
         endcase
      end
   end

   // State register plus a dedicated flop so in_ready_o has no state decode
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_r    <= ST_EMPTY;
         not_skid_r <= 1'b1;
      end else begin
         state_r    <= state_nxt_s;
         not_skid_r <= (state_nxt_s != ST_SKID);
      end
   end

   gnrl_dfflrd #(
      .DW      (DW),
      .RST_VAL (NOP_VAL)
   ) u_main (
      .clk  (clk),
      .rstn (rstn),
      .lden (main_ld_s),
      .dnxt (main_nxt_s),
      .qout (main_q_s)
   );

   generate
      if (SKID != 0) begin : g_skid
         gnrl_dfflrd #(
            .DW      (DW),
            .RST_VAL (NOP_VAL)
         ) u_skid (
            .clk  (clk),
            .rstn (rstn),
            .lden (skid_ld_s),
            .dnxt (skid_nxt_s),
            .qout (skid_q_s)
         );
      end else begin : g_no_skid
         assign skid_q_s = NOP_VAL;
      end
   endgenerate

   assign in_ready_o  = in_ready_s;
   assign out_valid_o = out_valid_s;
   assign out_data_o  = (state_r != ST_EMPTY) ? main_q_s : NOP_VAL;
   assign occ_o       = state_r;

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Self-checking bench: a SKID=1 and a SKID=0 instance share one stimulus
// stream; each is compared every cycle against a queue-based model.
module tb_pipe_skid_reg;
   import pipe_skid_reg_pkg::*;

   logic        clk;
   logic        rstn;
   logic [4:0]  hold_en;
   logic        flush;
   logic        in_valid;
   logic [31:0] in_data;
   logic        out_ready;
   logic        in_ready_a, out_valid_a, in_ready_b, out_valid_b;
   logic [31:0] out_data_a, out_data_b;
   logic [1:0]  occ_a, occ_b;

   int          n_vec = 0;
   int          n_err = 0;
   bit          chk_en = 1'b0;
   logic [31:0] qa[$];
   logic [31:0] qb[$];

   pipe_skid_reg #(.DW(32), .NOP_VAL(INST_NOP), .SKID(1), .CTRL_W(5), .HOLD_BIT(HOLD_MEM)) dut_a (
      .clk(clk), .rstn(rstn), .hold_en_i(hold_en), .flush_i(flush),
      .in_valid_i(in_valid), .in_ready_o(in_ready_a), .in_data_i(in_data),
      .out_valid_o(out_valid_a), .out_ready_i(out_ready), .out_data_o(out_data_a), .occ_o(occ_a));

   pipe_skid_reg #(.DW(32), .NOP_VAL(INST_NOP), .SKID(0), .CTRL_W(5), .HOLD_BIT(HOLD_MEM)) dut_b (
      .clk(clk), .rstn(rstn), .hold_en_i(hold_en), .flush_i(flush),
      .in_valid_i(in_valid), .in_ready_o(in_ready_b), .in_data_i(in_data),
      .out_valid_o(out_valid_b), .out_ready_i(out_ready), .out_data_o(out_data_b), .occ_o(occ_b));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
      end
   endtask

   // Apply one cycle of inputs, compare both DUTs to the model, advance the model
   task automatic step(input logic rn, input logic fl, input logic iv, input logic orr,
                       input logic [4:0] he, input logic [31:0] d);
      logic        hold;
      logic        ea_rdy, ea_vld, eb_rdy, eb_vld;
      logic [31:0] ea_dat, eb_dat;
      rstn = rn; flush = fl; in_valid = iv; out_ready = orr; hold_en = he; in_data = d;
      @(negedge clk);
      hold   = he[HOLD_MEM];
      ea_vld = (qa.size() != 0) && !hold;
      ea_rdy = (qa.size() < 2) && !hold;
      ea_dat = (qa.size() != 0) ? qa[0] : INST_NOP;
      eb_vld = (qb.size() != 0) && !hold;
      eb_rdy = ((qb.size() == 0) || orr) && !hold;
      eb_dat = (qb.size() != 0) ? qb[0] : INST_NOP;
      if (chk_en) begin
         chk("a_in_ready",  {31'd0, in_ready_a},  {31'd0, ea_rdy});
         chk("a_out_valid", {31'd0, out_valid_a}, {31'd0, ea_vld});
         chk("a_out_data",  out_data_a, ea_dat);
         chk("a_occ",       {30'd0, occ_a}, qa.size());
         chk("b_in_ready",  {31'd0, in_ready_b},  {31'd0, eb_rdy});
         chk("b_out_valid", {31'd0, out_valid_b}, {31'd0, eb_vld});
         chk("b_out_data",  out_data_b, eb_dat);
         chk("b_occ",       {30'd0, occ_b}, qb.size());
      end
      @(posedge clk);
      if (!rn || fl) begin
         qa.delete();
         qb.delete();
      end else if (!hold) begin
         if (ea_vld && orr) void'(qa.pop_front());
         if (iv && ea_rdy)  qa.push_back(d);
         if (eb_vld && orr) void'(qb.pop_front());
         if (iv && eb_rdy)  qb.push_back(d);
      end
      #1;
   endtask

   initial begin
      logic        r_rn, r_fl, r_iv, r_or;
      logic [4:0]  r_he;
      logic [31:0] r_d;

      // Reset; the first edge precedes any defined state so it is not compared
      step(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
      chk_en = 1'b1;
      step(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
      chk("lit_rst_occ",  {30'd0, occ_a}, 32'd0);
      chk("lit_rst_data", out_data_a, 32'h0000_0013);

      // Stream 1,2,3 with the consumer always ready
      step(1'b1, 1'b0, 1'b1, 1'b1, 5'd0, 32'h1);
      chk("lit_stream1", out_data_a, 32'h1);
      step(1'b1, 1'b0, 1'b1, 1'b1, 5'd0, 32'h2);
      chk("lit_stream2", out_data_b, 32'h2);
      step(1'b1, 1'b0, 1'b1, 1'b1, 5'd0, 32'h3);
      chk("lit_stream3", out_data_a, 32'h3);
      chk("lit_stream_occ", {30'd0, occ_a}, 32'd1);
      chk("lit_stream_rdy", {31'd0, in_ready_a}, 32'd1);
      step(1'b1, 1'b0, 1'b0, 1'b1, 5'd0, 32'd0);

      // Back-pressure: 0xA held, 0xB pushed against a stalled consumer
      step(1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 32'hA);
      step(1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 32'hB);
      chk("lit_skid_occ_a", {30'd0, occ_a}, 32'd2);
      chk("lit_skid_rdy_a", {31'd0, in_ready_a}, 32'd0);
      chk("lit_skid_occ_b", {30'd0, occ_b}, 32'd1);
      chk("lit_skid_rdy_b", {31'd0, in_ready_b}, 32'd0);
      step(1'b1, 1'b0, 1'b1, 1'b1, 5'd0, 32'hB);
      chk("lit_drain_a", out_data_a, 32'hB);
      chk("lit_drain_b", out_data_b, 32'hB);
      step(1'b1, 1'b0, 1'b0, 1'b1, 5'd0, 32'd0);

      // Flush with both entries occupied and a concurrent input
      step(1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 32'h10);
      step(1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 32'h11);
      step(1'b1, 1'b1, 1'b1, 1'b0, 5'd0, 32'hC);
      chk("lit_flush_occ",  {30'd0, occ_a}, 32'd0);
      chk("lit_flush_data", out_data_a, 32'h0000_0013);

      // Hold for three cycles while 0xD is resident
      step(1'b1, 1'b0, 1'b1, 1'b1, 5'd0, 32'hD);
      for (int i = 0; i < 3; i++) begin
         step(1'b1, 1'b0, 1'b0, 1'b1, 5'b01000, 32'd0);
         chk("lit_hold_data", out_data_a, 32'hD);
         chk("lit_hold_vld",  {31'd0, out_valid_a}, 32'd0);
         chk("lit_hold_rdy",  {31'd0, in_ready_b}, 32'd0);
      end
      step(1'b1, 1'b0, 1'b0, 1'b1, 5'd0, 32'd0);
      chk("lit_hold_release_occ", {30'd0, occ_a}, 32'd0);

      // Reset while two entries are held
      step(1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 32'h20);
      step(1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 32'h21);
      step(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
      chk("lit_rst_skid_occ",  {30'd0, occ_a}, 32'd0);
      chk("lit_rst_skid_data", out_data_a, 32'h0000_0013);

      // Randomised traffic; non-hold bits of the ctrl vector toggle freely
      for (int i = 0; i < 3000; i++) begin
         r_rn = ($urandom_range(0, 99) != 0);
         r_fl = ($urandom_range(0, 49) == 0);
         r_iv = ($urandom_range(0, 3) != 0);
         r_or = ($urandom_range(0, 2) != 0);
         r_he = 5'($urandom_range(0, 31)) & 5'b10111;
         if ($urandom_range(0, 9) == 0) r_he = r_he | 5'b01000;
         r_d  = $urandom;
         step(r_rn, r_fl, r_iv, r_or, r_he, r_d);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
